// File: rtl/lcd_fb_prefetch_ctrl.sv
// ---------------------------------------------------------------------------
// lcd_fb_prefetch_ctrl
// Schedules burst reads from the frame buffer into the LCD line FIFO. It
// walks the frame line by line in bursts of up to BURST_LEN pixels. It only
// asks for a burst when the whole burst fits in the FIFO. Every lcd_vs
// rising edge restarts the walk from the frame origin. A sticky flag records
// whether the display ever read from an empty FIFO.
//
// Ports
//   pclk, rst            pixel clock, async active-high reset
//   h_disp, v_disp       active pixels/lines, captured at frame restart
//   lcd_vs, lcd_de       sync / data-enable from the LCD timing driver
//   buf_level            current line FIFO fill in pixels
//   rd_req/addr/len      burst request towards the memory arbiter
//   rd_ack, rd_done      request accepted / burst fully written to FIFO
//   buf_flush            one-cycle FIFO clear at frame restart
//   frame_start          one-cycle pulse at frame restart
//   busy                 walking a frame (not IDLE / DONE)
//   underrun             sticky: display read an empty FIFO
// ---------------------------------------------------------------------------
module lcd_fb_prefetch_ctrl #(
    parameter int                ADDR_W      = 24,
    parameter logic [ADDR_W-1:0] FB_BASE     = '0,
    parameter int                LINE_STRIDE = 2048,
    parameter int                BURST_LEN   = 64,
    parameter int                BUF_DEPTH   = 1024
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic [10:0]       h_disp,
    input  logic [10:0]       v_disp,
    input  logic              lcd_vs,
    input  logic              lcd_de,
    input  logic [11:0]       buf_level,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_len,
    input  logic              rd_ack,
    input  logic              rd_done,
    output logic              buf_flush,
    output logic              frame_start,
    output logic              busy,
    output logic              underrun
);

    // state | meaning
    // IDLE  | out of reset, waiting for the first vs edge
    // FLUSH | clear FIFO, capture frame geometry
    // ARM   | size next burst, wait for FIFO room
    // REQ   | rd_req held until rd_ack
    // WAIT  | burst in flight, waiting for rd_done
    // DONE  | frame fully fetched, waiting for vs edge
    typedef enum logic [2:0] {
        S_IDLE, S_FLUSH, S_ARM, S_REQ, S_WAIT, S_DONE
    } state_t;

    localparam logic [10:0]       BURST_11  = BURST_LEN[10:0];
    localparam logic [7:0]        BURST_8   = BURST_LEN[7:0];
    localparam logic [12:0]       DEPTH_13  = BUF_DEPTH[12:0];
    localparam logic [ADDR_W-1:0] STRIDE_AW = LINE_STRIDE[ADDR_W-1:0];

    state_t              state_q, state_d;
    logic                vs_q;
    logic [10:0]         h_l_q, h_l_d, v_l_q, v_l_d;
    logic [10:0]         line_q, line_d, pix_q, pix_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          len_q, len_d;
    logic                pend_q, pend_d;
    logic                rd_req_q, rd_req_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [7:0]          rd_len_q, rd_len_d;
    logic                buf_flush_q, buf_flush_d;
    logic                frame_start_q, frame_start_d;
    logic                busy_q, busy_d;
    logic                underrun_q, underrun_d;

    logic                vs_edge;
    logic                go_flush;
    logic [10:0]         rem;
    logic [7:0]          len_c;
    logic                space_ok;
    logic [10:0]         pix_sum;
    logic [10:0]         line_inc;

    assign vs_edge  = lcd_vs & ~vs_q;
    assign rem      = h_l_q - pix_q;
    assign len_c    = (rem > BURST_11) ? BURST_8 : rem[7:0];
    // 13 bits so a full FIFO plus a maximum burst cannot wrap
    assign space_ok = ({1'b0, buf_level} + {5'b0, len_c}) <= DEPTH_13;
    assign pix_sum  = pix_q + {3'b0, len_q};
    assign line_inc = line_q + 11'd1;

    always_comb begin
        state_d       = state_q;
        h_l_d         = h_l_q;
        v_l_d         = v_l_q;
        line_d        = line_q;
        pix_d         = pix_q;
        addr_d        = addr_q;
        len_d         = len_q;
        pend_d        = pend_q;
        rd_req_d      = rd_req_q;
        rd_addr_d     = rd_addr_q;
        rd_len_d      = rd_len_q;
        buf_flush_d   = 1'b0;
        frame_start_d = 1'b0;
        go_flush      = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (vs_edge) go_flush = 1'b1;
            end
            S_FLUSH: begin
                h_l_d   = h_disp;
                v_l_d   = v_disp;
                line_d  = '0;
                pix_d   = '0;
                addr_d  = FB_BASE;
                pend_d  = 1'b0;
                state_d = (h_disp == '0 || v_disp == '0) ? S_DONE : S_ARM;
            end
            S_ARM: begin
                if (vs_edge) begin
                    go_flush = 1'b1;
                end else if (space_ok) begin
                    state_d   = S_REQ;
                    len_d     = len_c;
                    rd_req_d  = 1'b1;
                    rd_addr_d = addr_q + {{(ADDR_W-11){1'b0}}, pix_q};
                    rd_len_d  = len_c;
                end
            end
            S_REQ: begin
                // An accepted burst must complete, so a coincident vs edge
                // is deferred until its rd_done.
                if (rd_ack) begin
                    rd_req_d = 1'b0;
                    state_d  = S_WAIT;
                    if (vs_edge) pend_d = 1'b1;
                end else if (vs_edge) begin
                    rd_req_d = 1'b0;
                    go_flush = 1'b1;
                end
            end
            S_WAIT: begin
                if (vs_edge) pend_d = 1'b1;
                if (rd_done) begin
                    if (pend_q || vs_edge) begin
                        pend_d   = 1'b0;
                        go_flush = 1'b1;
                    end else if (pix_sum >= h_l_q) begin
                        pix_d   = '0;
                        line_d  = line_inc;
                        addr_d  = addr_q + STRIDE_AW;
                        state_d = (line_inc == v_l_q) ? S_DONE : S_ARM;
                    end else begin
                        pix_d   = pix_sum;
                        state_d = S_ARM;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (go_flush) begin
            state_d       = S_FLUSH;
            buf_flush_d   = 1'b1;
            frame_start_d = 1'b1;
        end

        busy_d = !(state_d == S_IDLE || state_d == S_DONE);

        // Clear in FLUSH takes priority over a same-cycle set.
        underrun_d = underrun_q;
        if (state_q == S_FLUSH)
            underrun_d = 1'b0;
        else if (lcd_de && buf_level == '0 && state_q != S_IDLE)
            underrun_d = 1'b1;
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            vs_q          <= 1'b0;
            h_l_q         <= '0;
            v_l_q         <= '0;
            line_q        <= '0;
            pix_q         <= '0;
            addr_q        <= '0;
            len_q         <= '0;
            pend_q        <= 1'b0;
            rd_req_q      <= 1'b0;
            rd_addr_q     <= '0;
            rd_len_q      <= '0;
            buf_flush_q   <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            vs_q          <= lcd_vs;
            h_l_q         <= h_l_d;
            v_l_q         <= v_l_d;
            line_q        <= line_d;
            pix_q         <= pix_d;
            addr_q        <= addr_d;
            len_q         <= len_d;
            pend_q        <= pend_d;
            rd_req_q      <= rd_req_d;
            rd_addr_q     <= rd_addr_d;
            rd_len_q      <= rd_len_d;
            buf_flush_q   <= buf_flush_d;
            frame_start_q <= frame_start_d;
            busy_q        <= busy_d;
            underrun_q    <= underrun_d;
        end
    end

    assign rd_req      = rd_req_q;
    assign rd_addr     = rd_addr_q;
    assign rd_len      = rd_len_q;
    assign buf_flush   = buf_flush_q;
    assign frame_start = frame_start_q;
    assign busy        = busy_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_lcd_fb_prefetch_ctrl.sv
// ---------------------------------------------------------------------------
// Bench for lcd_fb_prefetch_ctrl. Inputs are driven and outputs sampled on
// the falling edge of pclk. The expected burst lists come from walking the
// frame geometry with nested loops.
// ---------------------------------------------------------------------------
module tb_lcd_fb_prefetch_ctrl;

    localparam logic [23:0] FB_BASE = 24'hFFF000;

    logic        pclk = 1'b0;
    logic        rst;
    logic [10:0] h_disp, v_disp;
    logic        lcd_vs, lcd_de;
    logic [11:0] buf_level;
    logic        rd_req;
    logic [23:0] rd_addr;
    logic [7:0]  rd_len;
    logic        rd_ack, rd_done;
    logic        buf_flush, frame_start, busy, underrun;

    lcd_fb_prefetch_ctrl #(
        .ADDR_W(24), .FB_BASE(FB_BASE), .LINE_STRIDE(2048),
        .BURST_LEN(64), .BUF_DEPTH(1024)
    ) dut (
        .pclk(pclk), .rst(rst), .h_disp(h_disp), .v_disp(v_disp),
        .lcd_vs(lcd_vs), .lcd_de(lcd_de), .buf_level(buf_level),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
        .rd_ack(rd_ack), .rd_done(rd_done), .buf_flush(buf_flush),
        .frame_start(frame_start), .busy(busy), .underrun(underrun)
    );

    always #5 pclk = ~pclk;

    int total = 0;
    int bad   = 0;
    logic [23:0] got_a[$];
    logic [7:0]  got_l[$];

    typedef struct {
        int h;
        int lvl;
        bit exp_req;
        int exp_len;
        bit exp_busy;
    } vec_t;
    vec_t vecs [0:11];

    task automatic step();
        @(negedge pclk);
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_vs();
        lcd_vs = 1'b1;
        step();
        lcd_vs = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        int n = 0;
        while (rd_req !== 1'b1 && n < 64) begin
            step();
            n++;
        end
        ok = (rd_req === 1'b1);
    endtask

    // Plays the memory side for one burst and checks it against exp_*.
    task automatic serve_burst(input int ack_dly, input int done_dly,
                               input logic [23:0] exp_a, input logic [7:0] exp_l,
                               output bit ok, output bit tmo);
        bit seen;
        ok  = 1'b1;
        tmo = 1'b0;
        wait_req(seen);
        if (!seen) begin
            ok  = 1'b0;
            tmo = 1'b1;
            return;
        end
        got_a.push_back(rd_addr);
        got_l.push_back(rd_len);
        if (rd_addr !== exp_a || rd_len !== exp_l) ok = 1'b0;
        repeat (ack_dly) begin
            step();
            if (rd_req !== 1'b1 || rd_addr !== exp_a || rd_len !== exp_l) ok = 1'b0;
        end
        rd_ack = 1'b1;
        step();
        rd_ack = 1'b0;
        if (rd_req !== 1'b0) ok = 1'b0;
        repeat (done_dly - 1) begin
            step();
            if (rd_req !== 1'b0) ok = 1'b0;
        end
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
    endtask

    task automatic run_frame(input int h, input int v, input bit rnd,
                             output int nbad, output int nserved);
        logic [23:0] exp_a[$];
        logic [7:0]  exp_l[$];
        int blen;
        bit ok, tmo;
        for (int ln = 0; ln < v; ln++) begin
            for (int p = 0; p < h; p += blen) begin
                blen = (h - p > 64) ? 64 : h - p;
                exp_a.push_back(24'(int'(FB_BASE) + ln * 2048 + p));
                exp_l.push_back(8'(blen));
            end
        end
        h_disp = 11'(h);
        v_disp = 11'(v);
        got_a.delete();
        got_l.delete();
        nbad = 0;
        nserved = 0;
        apply_vs();
        foreach (exp_a[i]) begin
            if (rnd) buf_level = 12'($urandom_range(0, 900));
            serve_burst(rnd ? int'($urandom_range(0, 4)) : 3,
                        rnd ? int'($urandom_range(1, 6)) : 10,
                        exp_a[i], exp_l[i], ok, tmo);
            if (tmo) break;
            nserved++;
            if (!ok) nbad++;
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok, flag;
        int nbad, nserved, h, v;

        vecs[0]  = '{480,    0, 1, 64, 1};
        vecs[1]  = '{480, 1000, 0,  0, 1};
        vecs[2]  = '{480,  960, 1, 64, 1};
        vecs[3]  = '{480,  961, 0,  0, 1};
        vecs[4]  = '{ 20, 1004, 1, 20, 1};
        vecs[5]  = '{ 20, 1005, 0,  0, 1};
        vecs[6]  = '{ 64,    0, 1, 64, 1};
        vecs[7]  = '{ 65,    0, 1, 64, 1};
        vecs[8]  = '{  1, 1023, 1,  1, 1};
        vecs[9]  = '{  1, 4095, 0,  0, 1};
        vecs[10] = '{  0,    0, 0,  0, 0};
        vecs[11] = '{2047, 500, 1, 64, 1};

        rst = 1'b1;
        h_disp = '0; v_disp = '0; lcd_vs = 1'b0; lcd_de = 1'b0;
        buf_level = '0; rd_ack = 1'b0; rd_done = 1'b0;
        repeat (3) step();
        chk("rst_rd_req", rd_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flush", buf_flush, 0);
        rst = 1'b0;

        // IDLE ignores underrun conditions.
        lcd_de = 1'b1;
        repeat (2) step();
        lcd_de = 1'b0;
        chk("idle_no_underrun", underrun, 0);

        // Restart latency and FIFO-room gating.
        for (int i = 0; i < 12; i++) begin
            h_disp = 11'(vecs[i].h);
            v_disp = 11'd8;
            buf_level = 12'(vecs[i].lvl);
            apply_vs();
            chk($sformatf("vec%0d_flush", i), buf_flush, 1);
            chk($sformatf("vec%0d_fstart", i), frame_start, 1);
            step();
            chk($sformatf("vec%0d_flush_off", i), buf_flush, 0);
            step();
            chk($sformatf("vec%0d_req", i), rd_req, vecs[i].exp_req);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
            if (vecs[i].exp_req) begin
                chk($sformatf("vec%0d_len", i), rd_len, vecs[i].exp_len);
                chk($sformatf("vec%0d_addr", i), rd_addr, FB_BASE);
            end
        end

        // Stall in ARM, then release by draining the FIFO.
        h_disp = 11'd480; v_disp = 11'd8; buf_level = 12'd1000;
        apply_vs();
        flag = 1'b1;
        repeat (6) begin
            step();
            if (rd_req) flag = 1'b0;
        end
        chk("stall_no_req", flag, 1);
        buf_level = 12'd960;
        step();
        chk("stall_release_req", rd_req, 1);
        chk("stall_release_len", rd_len, 64);

        // Underrun set, hold, and clear-wins in FLUSH.
        buf_level = '0;
        lcd_de = 1'b1;
        step();
        lcd_de = 1'b0;
        chk("underrun_set", underrun, 1);
        repeat (5) step();
        chk("underrun_hold", underrun, 1);
        apply_vs();
        lcd_de = 1'b1;
        step();
        lcd_de = 1'b0;
        chk("underrun_clear_wins", underrun, 0);
        step();
        chk("underrun_stays_clear", underrun, 0);

        // Async reset while requesting.
        lcd_de = 1'b1;
        step();
        lcd_de = 1'b0;
        chk("pre_rst_req", rd_req, 1);
        chk("pre_rst_underrun", underrun, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_req", rd_req, 0);
        chk("async_rst_addr", rd_addr, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_underrun", underrun, 0);
        step();
        rst = 1'b0;
        flag = 1'b1;
        repeat (10) begin
            step();
            if (rd_req || busy || buf_flush) flag = 1'b0;
        end
        chk("post_rst_idle", flag, 1);

        // vs edge while a burst is in flight.
        h_disp = 11'd480; v_disp = 11'd272; buf_level = '0;
        apply_vs();
        wait_req(ok);
        chk("wait_first_req", ok, 1);
        rd_ack = 1'b1;
        step();
        rd_ack = 1'b0;
        apply_vs();
        flag = 1'b1;
        repeat (5) begin
            step();
            if (rd_req || buf_flush || frame_start) flag = 1'b0;
        end
        chk("wait_vs_quiet", flag, 1);
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
        chk("wait_vs_flush", buf_flush, 1);
        chk("wait_vs_fstart", frame_start, 1);
        step();
        chk("wait_vs_flush_off", buf_flush, 0);
        step();
        chk("wait_vs_req", rd_req, 1);
        chk("wait_vs_addr", rd_addr, FB_BASE);

        // Empty frame geometry.
        v_disp = '0;
        apply_vs();
        chk("vzero_flush", buf_flush, 1);
        step();
        chk("vzero_busy", busy, 0);
        flag = 1'b1;
        repeat (10) begin
            step();
            if (rd_req) flag = 1'b0;
        end
        chk("vzero_no_req", flag, 1);

        // Full 480x272 frame.
        buf_level = '0;
        run_frame(480, 272, 1'b0, nbad, nserved);
        chk("full_bursts", nserved, 2176);
        chk("full_bad", nbad, 0);
        if (got_a.size() == 2176) begin
            chk("full_b0_len", got_l[0], 64);
            chk("full_b7_len", got_l[7], 32);
            chk("full_b8_addr", got_a[8], 24'hFFF800);
            chk("full_last_addr", got_a[2175], 24'h0869C0);
        end
        step();
        chk("full_done_busy", busy, 0);
        chk("full_done_req", rd_req, 0);

        // Random geometries and memory latencies.
        for (int r = 0; r < 6; r++) begin
            h = int'($urandom_range(1, 200));
            v = int'($urandom_range(1, 3));
            run_frame(h, v, 1'b1, nbad, nserved);
            chk($sformatf("rand%0d_bursts", r), nserved, v * ((h + 63) / 64));
            chk($sformatf("rand%0d_bad", r), nbad, 0);
            repeat (3) step();
            chk($sformatf("rand%0d_busy", r), busy, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
